// File: rtl/pcie_req_initiator.sv
// pcie_req_initiator
//   Requester side of the pcie_if request/completion protocol. Local read/write
//   commands become MRd/MWr requests on a valid/ready channel. Reads get the
//   lowest free tag; returning completions are matched by tag and delivered as
//   one-cycle responses. A per-tag timer retires reads whose completion never
//   arrives.
//
//   Ports
//     clk, rst_n                   clock, async active-low reset
//     cmd_valid/ready/write/addr/data   local command channel
//     req_valid/ready/type/addr/data/tag  outgoing TLP request channel
//     cpl_valid/status/tag/data    incoming completions (no backpressure)
//     rsp_valid/tag/data/status/timeout  read response pulse
//     err_unexp                    pulse on completion for free/out-of-range tag
//     outstanding                  number of busy tags
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | no request pending; commands may be accepted
//   S_REQ  | request presented, req_* frozen until req_ready

package pcie_pkg;
   typedef enum logic [1:0] {
      TLP_MRd  = 2'd0,
      TLP_MWr  = 2'd1,
      TLP_CplD = 2'd2,
      TLP_Cpl  = 2'd3
   } tlp_type_e;
endpackage

module pcie_req_initiator
   import pcie_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_TAGS = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [ADDR_W-1:0]             cmd_addr,
   input  logic [DATA_W-1:0]             cmd_data,
   output logic                          req_valid,
   input  logic                          req_ready,
   output tlp_type_e                     req_type,
   output logic [ADDR_W-1:0]             req_addr,
   output logic [DATA_W-1:0]             req_data,
   output logic [7:0]                    req_tag,
   input  logic                          cpl_valid,
   input  logic [2:0]                    cpl_status,
   input  logic [7:0]                    cpl_tag,
   input  logic [DATA_W-1:0]             cpl_data,
   output logic                          rsp_valid,
   output logic [7:0]                    rsp_tag,
   output logic [DATA_W-1:0]             rsp_data,
   output logic [2:0]                    rsp_status,
   output logic                          rsp_timeout,
   output logic                          err_unexp,
   output logic [$clog2(NUM_TAGS+1)-1:0] outstanding
);

   localparam int CNT_W = $clog2(NUM_TAGS+1);
   localparam int TMR_W = $clog2(TIMEOUT+1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

   typedef enum logic {S_IDLE, S_REQ} state_e;

   state_e              state, state_nxt;
   logic [NUM_TAGS-1:0] tag_busy, tag_issued;
   logic [TMR_W-1:0]    tag_timer [NUM_TAGS];

   logic                any_free, accept, handshake;
   logic [7:0]          alloc_tag, to_tag;
   logic                to_hit, cpl_hit;
   logic [NUM_TAGS-1:0] rel_mask, alloc_mask, busy_nxt;
   logic [CNT_W-1:0]    cnt_nxt;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)    state_nxt = S_REQ;
         S_REQ:   if (req_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // rst_n in the ready term keeps commands blocked while reset is held
   always_comb begin
      req_valid = (state == S_REQ);
      cmd_ready = rst_n && (state == S_IDLE) && (cmd_write || any_free);
   end

   assign accept    = cmd_valid && cmd_ready;
   assign handshake = req_valid && req_ready;

   // ---------------- tag scan ----------------
   // Scanning high-to-low leaves the lowest matching index in alloc_tag/to_tag.
   always_comb begin
      any_free  = 1'b0;
      alloc_tag = '0;
      to_hit    = 1'b0;
      to_tag    = '0;
      cpl_hit   = 1'b0;
      rel_mask  = '0;
      for (int i = NUM_TAGS-1; i >= 0; i--) begin
         if (!tag_busy[i]) begin
            any_free  = 1'b1;
            alloc_tag = 8'(i);
         end
         if (tag_busy[i] && tag_issued[i] && tag_timer[i] == TMR_MAX) begin
            to_hit = 1'b1;
            to_tag = 8'(i);
         end
         if (cpl_valid && tag_busy[i] && cpl_tag == 8'(i)) begin
            cpl_hit     = 1'b1;
            rel_mask[i] = 1'b1;
         end
      end
      // A completion owns the response slot; expired tags stay saturated
      // and are retired on a later cycle.
      if (!cpl_hit && to_hit) begin
         for (int i = 0; i < NUM_TAGS; i++)
            if (to_tag == 8'(i)) rel_mask[i] = 1'b1;
      end
   end

   always_comb begin
      alloc_mask = '0;
      if (accept && !cmd_write) begin
         for (int i = 0; i < NUM_TAGS; i++)
            if (alloc_tag == 8'(i)) alloc_mask[i] = 1'b1;
      end
      busy_nxt = (tag_busy & ~rel_mask) | alloc_mask;
      cnt_nxt  = '0;
      for (int i = 0; i < NUM_TAGS; i++)
         cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
   end

   // ---------------- tag state and timers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_busy    <= '0;
         tag_issued  <= '0;
         outstanding <= '0;
         for (int i = 0; i < NUM_TAGS; i++) tag_timer[i] <= '0;
      end else begin
         tag_busy    <= busy_nxt;
         outstanding <= cnt_nxt;
         for (int i = 0; i < NUM_TAGS; i++) begin
            if (rel_mask[i]) begin
               tag_issued[i] <= 1'b0;
               tag_timer[i]  <= '0;
            end else if (handshake && req_type == TLP_MRd && req_tag == 8'(i)) begin
               tag_issued[i] <= 1'b1;
               tag_timer[i]  <= '0;
            end else if (tag_busy[i] && tag_issued[i] && tag_timer[i] != TMR_MAX) begin
               tag_timer[i]  <= tag_timer[i] + TMR_W'(1);
            end
         end
      end
   end

   // ---------------- request register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_type <= TLP_MRd;
         req_addr <= '0;
         req_data <= '0;
         req_tag  <= '0;
      end else if (accept) begin
         req_type <= cmd_write ? TLP_MWr : TLP_MRd;
         req_addr <= cmd_addr;
         req_data <= cmd_write ? cmd_data : '0;
         req_tag  <= cmd_write ? 8'd0 : alloc_tag;
      end
   end

   // ---------------- response / error ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_tag     <= '0;
         rsp_data    <= '0;
         rsp_status  <= '0;
         rsp_timeout <= 1'b0;
         err_unexp   <= 1'b0;
      end else begin
         rsp_valid <= cpl_hit || to_hit;
         err_unexp <= cpl_valid && !cpl_hit;
         if (cpl_hit) begin
            rsp_tag     <= cpl_tag;
            rsp_data    <= cpl_data;
            rsp_status  <= cpl_status;
            rsp_timeout <= 1'b0;
         end else if (to_hit) begin
            rsp_tag     <= to_tag;
            rsp_data    <= '0;
            rsp_status  <= 3'd7;
            rsp_timeout <= 1'b1;
         end
      end
   end

   a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid && !req_ready) |=> (req_valid && $stable(req_type) &&
         $stable(req_addr) && $stable(req_data) && $stable(req_tag)));

endmodule

// File: doc/pcie_req_initiator.md
# pcie_req_initiator

Requester end of the `pcie_if` request/completion protocol. It accepts local read and write commands and issues MRd/MWr TLP requests with a valid/ready handshake. It allocates tags for reads, matches returning completions by tag and delivers read responses to the local side. A per-tag timeout retires lost completions. The block sits between test or host logic and any completer on `pcie_if`.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, data width
- `NUM_TAGS`, 4, maximum outstanding reads (2..16); tags used are 0..NUM_TAGS-1
- `TIMEOUT`, 64, cycles from request handshake to completion timeout (≥4)

Ports:
- `clk` in 1, sole clock
- `rst_n` in 1, asynchronous active-low reset
- `cmd_valid` in 1, local command valid
- `cmd_ready` out 1, command accepted when `cmd_valid && cmd_ready` at posedge
- `cmd_write` in 1, 1=MWr, 0=MRd
- `cmd_addr` in ADDR_W, command address
- `cmd_data` in DATA_W, write data; ignored for reads
- `req_valid` out 1, request valid
- `req_ready` in 1, completer ready
- `req_type` out `tlp_type_e`, `TLP_MRd`/`TLP_MWr` (`pcie_pkg`)
- `req_addr` out ADDR_W, request address
- `req_data` out DATA_W, write data; 0 for MRd
- `req_tag` out 8, read tag; 0 for MWr
- `cpl_valid` in 1, completion valid; no backpressure
- `cpl_status` in 3, completion status
- `cpl_tag` in 8, completion tag
- `cpl_data` in DATA_W, completion data
- `rsp_valid` out 1, one-cycle read response pulse
- `rsp_tag` out 8, response tag
- `rsp_data` out DATA_W, read data; 0 on timeout
- `rsp_status` out 3, `cpl_status`, or 3'd7 on timeout
- `rsp_timeout` out 1, response caused by timeout
- `err_unexp` out 1, one-cycle pulse on a completion for a free or out-of-range tag
- `outstanding` out $clog2(NUM_TAGS+1), count of busy tags

## Operation
- FSM has 2 states:
  - IDLE: `req_valid`=0.
  - REQ: `req_valid`=1 and all `req_*` are held stable until `req_valid && req_ready` is sampled, then the FSM returns to IDLE.
- `cmd_ready` = (state==IDLE) && (`cmd_write` || any tag free).
- On command accept, `req_*` is registered and the FSM enters REQ.
  - For MRd, the lowest free tag is marked busy at accept time.
- MWr is posted: no tag is consumed and no completion is expected.
- At the MRd handshake, that tag's timer starts at 0.
- Each busy, issued tag's timer increments every cycle and saturates at TIMEOUT.
- Completion with `cpl_valid`=1 and busy `cpl_tag`:
  - Register `rsp_valid`=1, `rsp_tag`, `rsp_data`=`cpl_data`, `rsp_status`=`cpl_status`, `rsp_timeout`=0.
  - Free the tag.
- Completion with a free or ≥NUM_TAGS tag: pulse `err_unexp`, drop the completion, change no state.
- Timeout (timer==TIMEOUT):
  - Emit `rsp_valid`, `rsp_timeout`=1, `rsp_status`=3'd7, `rsp_data`=0.
  - Free the tag.
  - At most one response per cycle; among expired tags, the lowest tag goes first.
- Simultaneous events:
  - A completion beats a timeout. If both are for the same tag, the completion is reported and the timeout is discarded.
  - A pending timeout on another tag is reported in the next free cycle.
  - A tag freed this cycle is allocatable next cycle; it is not visible in `cmd_ready` this cycle.
  - Accept and free in the same cycle: `outstanding` nets both (±0).
- When all NUM_TAGS are busy, reads stall (`cmd_ready`=0) while writes are still accepted.
- Reset (any time, including mid-request):
  - Outputs: `cmd_ready`=0 during reset; `req_valid`=0, `req_type`=`TLP_MRd`, `req_addr`/`req_data`/`req_tag`=0.
  - Responses: `rsp_valid`=0, `rsp_*`=0, `rsp_timeout`=0.
  - Status: `err_unexp`=0, `outstanding`=0.
  - Internal: all tags free, all timers 0, FSM in IDLE.
  - Completions arriving after reset release are unexpected.

## Timing
- Command accept at posedge N → `req_valid`=1 from N+1.
- Back-to-back requests: after the handshake at posedge H, `cmd_ready` is high in cycle H+1, so the minimum spacing is 2 cycles per request.
- `req_*` must not change while `req_valid && !req_ready`; this is checked by SVA.
- `cpl_valid` sampled at posedge M → `rsp_valid` high for exactly the cycle after M.
- A timeout fires at the posedge where the timer reaches TIMEOUT; `rsp_valid` is high in the following cycle.
- `err_unexp` occurs in the cycle after the bad completion is sampled.

## Test plan
- Reset, then MWr 0x12345678 @0x10, then MRd @0x10 to a completer model returning mem^0xDEADBEEF → `rsp_data`=0xCC99E897, `rsp_tag`=0, `rsp_status`=0.
- Completer holds `req_ready`=0 for 3 cycles → `req_*` stable throughout; exactly one handshake.
- Issue 5 MRd with NUM_TAGS=4 and no completions → tags 0..3 issued, `outstanding`=4, `cmd_ready`=0 for the read, an interleaved MWr still accepted.
- Completions returned out of order (tags 2,0,3,1) → 4 `rsp_valid` pulses with matching tags and data, `outstanding` returns to 0.
- Completion with tag 5, then with a free tag 1 → two `err_unexp` pulses, no `rsp_valid`, `outstanding` unchanged.
- Two reads with no completion, TIMEOUT=8 → `rsp_timeout` for tag 0, then tag 1 in consecutive response cycles, `rsp_status`=7. Then reset asserted mid-REQ → `req_valid`=0 immediately, `outstanding`=0.
